// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder: FSM encoding,
// error flag values, word size and the address-legality helper.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic ERR_NONE   = 1'b0;
    localparam logic ERR_ADDR   = 1'b1;
    localparam int   WORD_BYTES = 4;

    // An access is illegal when it is not word aligned or lies beyond the array.
    function automatic logic addr_err(input logic [31:0] addr, input int aw);
        logic [31:0] above;
        above = addr >> (aw + 2);
        return ((addr[1:0] != 2'b00) || (above != 32'd0)) ? ERR_ADDR : ERR_NONE;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage: async clear, one synchronous write port and a
// read register that captures the addressed word (or clears) on the access edge.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [31:0]   wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_idx,
    input  logic          rd_clr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH];

    // NOTE: the array must read as zero after every reset, so it is built from resettable flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        rd_data <= '0;
        else if (rd_en)  rd_data <= mem[rd_idx];
        else if (rd_clr) rd_data <= '0;
    end

endmodule

// File: rtl/dmem_responder.sv
// Target end of the CPU load/store path: accepts one word request at a time,
// waits LATENCY cycles, accesses the array and returns data/error via valid/ready.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int AW      = 6,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam logic [3:0] LAT = 4'(LATENCY);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q, wdata_q;
    logic        req_ready_q, resp_valid_q, resp_err_q, busy_q;

    logic        accept, access, handshake;
    logic        acc_we, acc_err;
    logic [31:0] acc_addr, acc_wdata;

    always_comb begin
        // NOTE: every signal gets a default before the case so no branch can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        access    = 1'b0;
        handshake = resp_valid_q && resp_ready;
        accept    = (state_q == IDLE) && req_valid && req_ready_q;
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    // With zero latency the access uses the live request on the acceptance edge.
                    acc_we    = req_we;
                    acc_addr  = req_addr;
                    acc_wdata = req_wdata;
                    cnt_d     = LAT;
                    if (LAT == 4'd0) begin
                        state_d = RESP;
                        access  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    access  = 1'b1;
                end
            end
            RESP: begin
                if (handshake) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign acc_err = addr_err(acc_addr, AW);

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= ERR_NONE;
            busy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= (state_d == IDLE);
            busy_q      <= (state_d != IDLE);
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (access) begin
                resp_valid_q <= 1'b1;
                resp_err_q   <= acc_err;
            end else if (handshake) begin
                resp_valid_q <= 1'b0;
                resp_err_q   <= ERR_NONE;
            end
        end
    end

    dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (access && acc_we && !acc_err),
        .wr_idx  (acc_addr[AW+1:2]),
        .wr_data (acc_wdata),
        .rd_en   (access && !acc_we && !acc_err),
        .rd_idx  (acc_addr[AW+1:2]),
        .rd_clr  ((access && (acc_we || acc_err)) || handshake),
        .rd_data (resp_rdata)
    );

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign busy       = busy_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the CPU's data-memory request interface. It is the target end of the load/store path.
- Accepts one word request at a time from the initiator and models a configurable number of wait states.
- Owns the data word array, performs the read or write, and returns read data plus an error flag using a valid/ready handshake.
- Sits between the CPU load/store path and the data storage. It replaces the zero-latency memory, so the core can later be stalled on real memory timing.

Parameters:
- DEPTH, 64, number of 32-bit words stored; must be a power of two, 2..1024.
- AW, 6, word-index width; equals log2(DEPTH).
- LATENCY, 2, wait cycles between request acceptance and response; 0..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-low (0 = reset asserted).
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- resp_valid  output  1  response available.
- resp_ready  input  1  initiator consumes the response.
- resp_rdata  output  32  load data; 0 for stores and for errors.
- resp_err  output  1  misaligned or out-of-range access.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; counter = 0.
  - req_ready = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0, busy = 0.
  - All DEPTH words cleared to 0.
  - req_ready rises to 1 on the first clk edge after rst goes high.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - Acceptance occurs on an edge with req_valid & req_ready. On acceptance:
    - latch req_we, req_addr, req_wdata;
    - req_ready goes to 0;
    - counter loads LATENCY.
  - Next state is WAIT if LATENCY > 0, otherwise RESP.
- WAIT:
  - Counter decrements each cycle.
  - On the edge where counter == 1, go to RESP and perform the access on that same edge.
  - With LATENCY = 0, the access is performed on the acceptance edge itself.
- Access (performed on the edge entering RESP):
  - word index = addr[AW+1:2].
  - err = (addr[1:0] != 0) | (addr[31:AW+2] != 0).
  - Error: no write; resp_rdata = 0; resp_err = 1.
  - Store without error: write wdata to the word; resp_rdata = 0.
  - Load without error: resp_rdata = stored word, value as of before this edge.
- RESP:
  - resp_valid = 1; resp_rdata and resp_err are held stable until the handshake.
  - On an edge with resp_valid & resp_ready: resp_valid goes to 0, resp_rdata and resp_err go to 0, state = IDLE, req_ready goes to 1.
  - A new request is accepted no earlier than the cycle after the response handshake, so there is at most one outstanding request.
- Response latency from the acceptance edge to resp_valid high is LATENCY + 1 cycles.
- Request inputs are ignored outside IDLE. The initiator may change them freely after acceptance.
- Holding resp_ready low stalls the block in RESP indefinitely with no state change.
- Asserting rst in WAIT or RESP aborts the transaction immediately: the pending store is discarded and the array is cleared.
- Read-after-write to the same address returns the newly written value, because the transactions are strictly serialized.
- Counter width is 4 bits and never wraps, since LATENCY ≤ 15.

Decomposition:
- Shared package holds:
  - the state encoding constants IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
  - the ERR_NONE/ERR_ADDR flag constants;
  - the word-size constant 4.
- One natural sub-module, dmem_array: DEPTH×32 storage with async clear, one synchronous write port and one read port registered on the access edge.
- The FSM, counter and handshake registers stay in dmem_responder.

Test Plan:
- Reset then idle: hold rst = 0 for 3 cycles, release -> req_ready = 1 one edge later; resp_valid = 0; a load from 0x00000010 returns resp_rdata = 0, resp_err = 0.
- Store then load, LATENCY = 2: store 0xDEADBEEF to 0x00000008, then load 0x00000008 -> resp_valid rises exactly 3 cycles after each acceptance; load returns 0xDEADBEEF, resp_err = 0.
- Misaligned and out-of-range: store to 0x00000006, then store to 0x00000100 (DEPTH = 64) -> resp_err = 1 both times; a load of 0x00000004 afterwards returns 0 (no write occurred).
- Response backpressure: resp_ready held 0 for 5 cycles after resp_valid -> resp_valid and resp_rdata are stable, req_ready = 0, and a new req_valid is ignored; resp_ready = 1 -> IDLE next edge.
- Reset mid-transaction: accept a store of 0x12345678 to 0x0, pull rst low in WAIT -> all outputs reset at once; after release, a load of 0x0 returns 0.
- LATENCY = 0 build: load after store at 0x0000003C -> resp_valid 1 cycle after acceptance; back-to-back requests are accepted every 2 cycles with resp_ready tied 1.
